// File: rtl/colorloop_mlane.sv
// Scanline-chunk controller for the colour-fill stage: clears z/frame buffers on a new
// frame and spreads the rows of one chunk over LANES fill workers with req/ack handshakes.
module colorloop_mlane #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int CHUNK_SIZE = 16,
  parameter int LANES      = 2,
  parameter int ROW_W      = 16,
  parameter int ZADDR_W    = 19,
  parameter int FBADDR_W   = 19,
  parameter int LAYER_SIZE = 16,
  parameter logic [LAYER_SIZE-1:0] CLEAR_Z = '1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   new_frame,
  input  logic                   clear_fb_en,
  input  logic [23:0]            clear_color,
  input  logic                   color_en,
  input  logic [ROW_W-1:0]       start_row,
  input  logic                   all_done,
  output logic [LANES-1:0]       row_req,
  output logic [LANES*ROW_W-1:0] row_idx,
  input  logic [LANES-1:0]       row_ack,
  output logic [LANES-1:0]       lane_busy,
  output logic [ZADDR_W-1:0]     zbuf_addr,
  output logic [LAYER_SIZE-1:0]  zbuf_wdata,
  output logic                   zbuf_we,
  output logic [FBADDR_W-1:0]    fb_addr,
  output logic [23:0]            fb_wdata,
  output logic                   fb_we,
  output logic                   clear_busy,
  output logic                   ready,
  output logic                   done
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_DISPATCH, S_DRAIN, S_DONE} state_t;

  localparam logic [ZADDR_W-1:0] LAST_ADDR = ZADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [ROW_W:0]     HEIGHT_R  = (ROW_W + 1)'(HEIGHT);
  localparam logic [ROW_W:0]     CHUNK_R   = (ROW_W + 1)'(CHUNK_SIZE);

  state_t               state_q, state_d;
  logic [ZADDR_W-1:0]   clear_addr_q, clear_addr_d;
  logic                 pending_q, pending_d;
  logic                 pend_fb_en_q, pend_fb_en_d;
  logic [23:0]          pend_color_q, pend_color_d;
  logic                 fb_en_q, fb_en_d;
  logic [23:0]          color_q, color_d;
  logic [ROW_W:0]       next_row_q, next_row_d;
  logic [ROW_W:0]       end_row_q, end_row_d;
  logic [LANES-1:0]     lane_busy_q, lane_busy_d;
  logic [LANES-1:0]     issue_mask_s;
  logic                 issue_any_s;
  logic [ROW_W:0]       chunk_end_s;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      clear_addr_q <= '0;
      pending_q    <= 1'b0;
      pend_fb_en_q <= 1'b0;
      pend_color_q <= 24'h000000;
      fb_en_q      <= 1'b0;
      color_q      <= 24'h000000;
      next_row_q   <= '0;
      end_row_q    <= '0;
      lane_busy_q  <= '0;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
      pending_q    <= pending_d;
      pend_fb_en_q <= pend_fb_en_d;
      pend_color_q <= pend_color_d;
      fb_en_q      <= fb_en_d;
      color_q      <= color_d;
      next_row_q   <= next_row_d;
      end_row_q    <= end_row_d;
      lane_busy_q  <= lane_busy_d;
    end
  end

  // Pick the lowest-index free lane while rows remain; uses only registered busy flags
  always_comb begin
    issue_mask_s = '0;
    issue_any_s  = 1'b0;
    if (state_q == S_DISPATCH && next_row_q < end_row_q) begin
      for (int i = 0; i < LANES; i++) begin
        if (!issue_any_s && !lane_busy_q[i]) begin
          issue_mask_s[i] = 1'b1;
          issue_any_s     = 1'b1;
        end else begin
          issue_mask_s[i] = 1'b0;
        end
      end
    end else begin
      issue_mask_s = '0;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    pending_d    = pending_q;
    pend_fb_en_d = pend_fb_en_q;
    pend_color_d = pend_color_q;
    fb_en_d      = fb_en_q;
    color_d      = color_q;
    next_row_d   = next_row_q;
    end_row_d    = end_row_q;
    lane_busy_d  = (lane_busy_q & ~row_ack) | issue_mask_s;
    chunk_end_s  = {1'b0, start_row} + CHUNK_R;

    // A frame request seen while busy is remembered with its own fill settings
    if (new_frame && state_q != S_IDLE) begin
      pending_d    = 1'b1;
      pend_fb_en_d = clear_fb_en;
      pend_color_d = clear_color;
    end else begin
      pending_d    = pending_q;
    end

    case (state_q)
      S_IDLE: begin
        if (new_frame) begin
          state_d      = S_CLEAR;
          fb_en_d      = clear_fb_en;
          color_d      = clear_color;
          clear_addr_d = '0;
          pending_d    = 1'b0;
        end else if (pending_q) begin
          state_d      = S_CLEAR;
          fb_en_d      = pend_fb_en_q;
          color_d      = pend_color_q;
          clear_addr_d = '0;
          pending_d    = 1'b0;
        end else if (color_en) begin
          state_d    = S_DISPATCH;
          next_row_d = {1'b0, start_row};
          end_row_d  = (chunk_end_s > HEIGHT_R) ? HEIGHT_R : chunk_end_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (clear_addr_q == LAST_ADDR) begin
          state_d      = S_IDLE;
          clear_addr_d = '0;
        end else begin
          clear_addr_d = clear_addr_q + ZADDR_W'(1);
        end
      end
      S_DISPATCH: begin
        next_row_d = next_row_q + {{ROW_W{1'b0}}, issue_any_s};
        // >= also covers an empty chunk whose start lies beyond the frame
        if (next_row_d >= end_row_q) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_DISPATCH;
        end
      end
      S_DRAIN: begin
        if (lane_busy_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (all_done) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state only
  always_comb begin
    row_req    = issue_mask_s;
    row_idx    = '0;
    lane_busy  = lane_busy_q;
    clear_busy = (state_q == S_CLEAR);
    ready      = (state_q == S_IDLE);
    done       = (state_q == S_DONE);
    for (int i = 0; i < LANES; i++) begin
      if (issue_mask_s[i]) begin
        row_idx[i*ROW_W +: ROW_W] = next_row_q[ROW_W-1:0];
      end else begin
        row_idx[i*ROW_W +: ROW_W] = '0;
      end
    end
    if (state_q == S_CLEAR) begin
      zbuf_we    = 1'b1;
      zbuf_addr  = clear_addr_q;
      zbuf_wdata = CLEAR_Z;
      fb_we      = fb_en_q;
      fb_addr    = FBADDR_W'(clear_addr_q);
      fb_wdata   = color_q;
    end else begin
      zbuf_we    = 1'b0;
      zbuf_addr  = '0;
      zbuf_wdata = '0;
      fb_we      = 1'b0;
      fb_addr    = '0;
      fb_wdata   = 24'h000000;
    end
  end

endmodule
